mbc5_bus_scheduler: RTL and testbench
=====================================

Name: mbc5_bus_scheduler

Overview:
Clocked MBC5 controller that owns the cartridge memory bus and shares it between two requesters: the Game Boy (mapper register writes and bank translation) and a host loader port (flash/SRAM programming).
Synchronizes the asynchronous GB strobes into clk and decodes MBC5 register writes on strobe edges.
Hands the bus to the host only while the GB is held in reset, sequencing each host access through setup/strobe/hold phases.
Sits between the cartridge edge connector and the ROM/SRAM chips.

Parameters:
SYNC_STAGES, 2, flip-flop depth of GB input synchronizers (min 2)
SETUP_CYCLES, 1, host access: address/CS valid before strobe (min 1)
STROBE_CYCLES, 4, host access: oe_n/we_n low width (min 1)
HOLD_CYCLES, 1, host access: address/CS held after strobe rises (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
gb_rst_n  in  1  GB reset pin, asynchronous, synchronized internally
gb_write_n  in  1  GB write strobe, asynchronous
gb_read_n  in  1  GB read strobe, asynchronous
gb_cs_n  in  1  GB external-RAM chip select, asynchronous
gb_addr_hi  in  4  GB A15..A12
gb_data  in  8  GB data bus
host_req  in  1  host access request, level, held until host_ack
host_we  in  1  1 = write, 0 = read
host_sel_ram  in  1  1 = SRAM target, 0 = ROM/flash target
host_addr  in  23  host byte address
host_wdata  in  8  host write data
host_ack  out  1  one-cycle completion pulse
host_abort  out  1  qualifies host_ack: access aborted
host_rdata  out  8  read data, valid with host_ack
mem_din  in  8  memory data bus read-back
bus_owner  out  1  0 = GB owns bus, 1 = host owns bus
mem_addr_lo  out  14  host low address (drives A13..A0 only when bus_owner=1)
rom_hi  out  9  ROM A22..A14
ram_hi  out  4  SRAM A16..A13
rom_cs_n  out  1  ROM chip select
ram_cs_n  out  1  SRAM chip select
mem_oe_n  out  1  host-mode output enable
mem_we_n  out  1  host-mode write enable

Behaviour:
- rst_n low (async): rom_bank=9'h001, ram_bank=0, ram_en=0, FSM=IDLE.
- rst_n low outputs: host_ack=0, host_abort=0, host_rdata=0, bus_owner=0, mem_oe_n=1, mem_we_n=1, rom_cs_n=1, ram_cs_n=1.
- gb_rst_s (synchronized gb_rst_n) low also resets rom_bank, ram_bank and ram_en to the values above.
- gb_write_n, gb_read_n, gb_cs_n and gb_rst_n each pass through SYNC_STAGES flops. gb_addr_hi and gb_data are captured every clk while synced write_n is low.
- Register commit: on the synced write_n 0->1 edge, with gb_rst_s=1, the last captured addr/data is committed one clk later:
  - A15..13=000: ram_en = (data[3:0]==4'hA).
  - A15..12=0010: rom_bank[7:0] = data.
  - A15..12=0011: rom_bank[8] = data[0].
  - A15..13=010: ram_bank = data[3:0].
  - A15..13=011, or A15=1: no effect.
- Bank 0 is legal in rom_bank; no 0->1 remap.
- GB mode (bus_owner=0):
  - rom_hi = A14 ? rom_bank : 0. ram_hi = ram_bank.
  - rom_cs_n = ~(~A15 & ~gb_read_n), combinational from raw pins.
  - ram_cs_n = ~(~gb_cs_n & ~A14 & ram_en).
  - mem_oe_n=1, mem_we_n=1 (the GB drives the chips directly).
- bus_owner = ~gb_rst_s, registered.
- Host FSM: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE.
  - IDLE: accept when host_req=1 and bus_owner=1; latch all host fields. host_req while bus_owner=0 waits, with no ack.
  - SETUP (SETUP_CYCLES): rom_hi/ram_hi from host_addr, mem_addr_lo=host_addr[13:0], selected CS low.
  - STROBE (STROBE_CYCLES): mem_we_n or mem_oe_n low. Read data is sampled from mem_din on the last STROBE cycle.
  - HOLD (HOLD_CYCLES): strobes high, CS still low.
  - DONE: CS high, host_ack=1 for one cycle. Back to IDLE; a new request is accepted no earlier than the next cycle.
  - SRAM target: ram_hi=host_addr[16:13] and mem_addr_lo[13] is don't-care.
  - Total access latency from accept to host_ack = SETUP+STROBE+HOLD+1 clks.
- gb_rst_s rising (GB leaves reset) in SETUP/STROBE/HOLD:
  - The same cycle: strobes and CS high, bus_owner->0.
  - Next cycle: host_ack=1 with host_abort=1, FSM->IDLE.
  - In IDLE/DONE it has no effect beyond the ownership change.
- Simultaneous GB write edge and host access cannot occur (ownership is exclusive). GB strobes seen while bus_owner=1 are ignored.

Decomposition:
- Shared package mbc5_pkg:
  - register-region decode constants (RAMEN, ROMB0, ROMB1, RAMB).
  - reset values (ROM_BANK_RST=9'h001).
  - host FSM state enum.
- Sub-module gb_bus_sync: parameterized SYNC_STAGES, vector-width synchronizer with async active-low reset; reset value is 1 (strobes inactive).

Test Plan:
- Reset release, GB out of reset, write 0x0A to 0x0000 then read-cycle with gb_cs_n=0, A14=0 -> ram_en=1, ram_cs_n=0. Then write 0x00 -> ram_cs_n=1.
- Write 0x5A to 0x2000, 0x01 to 0x3000, A14=1 -> rom_hi=9'h15A. With A14=0 -> rom_hi=0. Write 0x00 to 0x2000 and 0x3000 -> rom_hi=0 (no remap).
- Write 0x0B to 0x4000 -> ram_hi=4'hB. Write to 0x6000 -> all registers unchanged.
- Hold gb_rst_n=0, host read of ROM 23'h123456 with mem_din=0xC3 -> rom_hi=9'h048, mem_addr_lo=14'h3456.
  - mem_oe_n low exactly 4 clks; host_ack 7 clks after accept (defaults); host_rdata=0xC3, host_abort=0.
- Host write to SRAM 23'h01E000 with data 0x77 -> ram_hi=4'hF, ram_cs_n low across SETUP..HOLD, mem_we_n low 4 clks, rom_cs_n=1 throughout.
- Release gb_rst_n mid-STROBE -> strobes/CS high within SYNC_STAGES+1 clks of the pin edge, host_ack with host_abort=1, bus_owner=0, registers at reset values.

Source files
------------

// File: rtl/mbc5_pkg.sv
// Shared definitions for the MBC5 bus scheduler.
//   - MBC5 register-region decode constants (upper address nibble / bits)
//   - Bank register reset values
//   - Host access FSM state enum
package mbc5_pkg;

  // Register regions, compared against A15..A13 (3-bit) or A15..A12 (4-bit).
  localparam logic [2:0] RegionRamEn = 3'b000;
  localparam logic [3:0] RegionRomB0 = 4'b0010;
  localparam logic [3:0] RegionRomB1 = 4'b0011;
  localparam logic [2:0] RegionRamB  = 3'b010;

  localparam logic [8:0] RomBankRst = 9'h001;
  localparam logic [3:0] RamBankRst = 4'h0;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StDone
  } host_state_e;

endpackage

// File: rtl/mbc5_bus_scheduler_if.sv
// Host loader port of the MBC5 bus scheduler.
//   req/we/sel_ram/addr/wdata : request fields, driven by the host (master)
//   ack/abort/rdata           : completion pulse, abort qualifier and read data (slave)
interface mbc5_bus_scheduler_if;
  logic        req;
  logic        we;
  logic        sel_ram;
  logic [22:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic        abort;
  logic [7:0]  rdata;

  modport master (
    output req, we, sel_ram, addr, wdata,
    input  ack, abort, rdata
  );

  modport slave (
    input  req, we, sel_ram, addr, wdata,
    output ack, abort, rdata
  );
endinterface

// File: rtl/gb_bus_sync.sv
// Multi-flop synchronizer for asynchronous Game Boy strobes.
//   clk, rst_n : clock and async active-low reset
//   d_i        : asynchronous input vector
//   q_o        : synchronized output; resets to all ones (strobes inactive)
module gb_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '1;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/mbc5_bus_scheduler.sv
// MBC5 controller sharing the cartridge memory bus between the Game Boy and a host loader.
//   clk, rst_n         : system clock, async active-low reset
//   gb_*_i             : raw (asynchronous) Game Boy cartridge-edge signals
//   host               : host loader request/ack port (slave side)
//   mem_din_i          : memory data read-back
//   mem_dout_o         : host write data towards the memory data bus
//   bus_owner_o        : 0 = GB owns bus, 1 = host owns bus
//   mem_addr_lo_o      : host A13..A0 (zero in GB mode)
//   rom_hi_o, ram_hi_o : banked upper ROM / SRAM address lines
//   rom_cs_n_o, ram_cs_n_o, mem_oe_n_o, mem_we_n_o : chip controls
module mbc5_bus_scheduler
  import mbc5_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                gb_rst_n_i,
  input  logic                gb_write_n_i,
  input  logic                gb_read_n_i,
  input  logic                gb_cs_n_i,
  input  logic [3:0]          gb_addr_hi_i,
  input  logic [7:0]          gb_data_i,
  mbc5_bus_scheduler_if.slave host,
  input  logic [7:0]          mem_din_i,
  output logic [7:0]          mem_dout_o,
  output logic                bus_owner_o,
  output logic [13:0]         mem_addr_lo_o,
  output logic [8:0]          rom_hi_o,
  output logic [3:0]          ram_hi_o,
  output logic                rom_cs_n_o,
  output logic                ram_cs_n_o,
  output logic                mem_oe_n_o,
  output logic                mem_we_n_o
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] SetupLast  = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] StrobeLast = CntW'(STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // GB input synchronization
  // ---------------------------------------------------------------------------
  logic [3:0] gb_raw, gb_sync;
  logic       gb_rst_s, gb_write_s;
  logic       unused_gb_sync;

  assign gb_raw = {gb_rst_n_i, gb_cs_n_i, gb_read_n_i, gb_write_n_i};

  gb_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .WIDTH      (4)
  ) u_gb_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (gb_raw),
    .q_o  (gb_sync)
  );

  assign gb_write_s = gb_sync[0];
  assign gb_rst_s   = gb_sync[3];
  // Read and CS reach the chips combinationally; their synced copies drive nothing.
  assign unused_gb_sync = ^gb_sync[2:1];

  // ---------------------------------------------------------------------------
  // Ownership and GB register-write capture
  // ---------------------------------------------------------------------------
  logic       bus_owner_q;
  logic [3:0] cap_addr_q;
  logic [7:0] cap_data_q;
  logic       we_prev_q;
  logic       commit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_owner_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_data_q  <= '0;
      we_prev_q   <= 1'b1;
      commit_q    <= 1'b0;
    end else begin
      bus_owner_q <= ~gb_rst_s;
      we_prev_q   <= gb_write_s;
      // GB strobes are ignored while the host owns the bus.
      commit_q    <= gb_write_s & ~we_prev_q & gb_rst_s & ~bus_owner_q;
      if (!gb_write_s && !bus_owner_q) begin
        cap_addr_q <= gb_addr_hi_i;
        cap_data_q <= gb_data_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // MBC5 bank registers
  // ---------------------------------------------------------------------------
  logic [8:0] rom_bank_q, rom_bank_d;
  logic [3:0] ram_bank_q, ram_bank_d;
  logic       ram_en_q, ram_en_d;

  always_comb begin
    rom_bank_d = rom_bank_q;
    ram_bank_d = ram_bank_q;
    ram_en_d   = ram_en_q;
    if (!gb_rst_s) begin
      rom_bank_d = RomBankRst;
      ram_bank_d = RamBankRst;
      ram_en_d   = 1'b0;
    end else if (commit_q) begin
      if (cap_addr_q[3:1] == RegionRamEn) begin
        ram_en_d = (cap_data_q[3:0] == 4'hA);
      end else if (cap_addr_q == RegionRomB0) begin
        rom_bank_d[7:0] = cap_data_q;
      end else if (cap_addr_q == RegionRomB1) begin
        rom_bank_d[8] = cap_data_q[0];
      end else if (cap_addr_q[3:1] == RegionRamB) begin
        ram_bank_d = cap_data_q[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_bank_q <= RomBankRst;
      ram_bank_q <= RamBankRst;
      ram_en_q   <= 1'b0;
    end else begin
      rom_bank_q <= rom_bank_d;
      ram_bank_q <= ram_bank_d;
      ram_en_q   <= ram_en_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Host access FSM
  // ---------------------------------------------------------------------------
  host_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            abort_q, abort_d;
  logic            accept;
  logic            sample_rd;
  logic [22:0]     haddr_q;
  logic            hwe_q, hsel_q;
  logic [7:0]      hwdata_q, rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (host.req && bus_owner_q && !gb_rst_s) begin
          accept  = 1'b1;
          state_d = StSetup;
          cnt_d   = '0;
        end
      end
      StSetup: begin
        if (gb_rst_s) begin
          state_d = StDone;
          abort_d = 1'b1;
        end else if (cnt_q == SetupLast) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStrobe: begin
        if (gb_rst_s) begin
          state_d = StDone;
          abort_d = 1'b1;
        end else if (cnt_q == StrobeLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (gb_rst_s) begin
          state_d = StDone;
          abort_d = 1'b1;
        end else if (cnt_q == HoldLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign sample_rd = (state_q == StStrobe) && (cnt_q == StrobeLast) && !gb_rst_s && !hwe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      haddr_q  <= '0;
      hwe_q    <= 1'b0;
      hsel_q   <= 1'b0;
      hwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      if (accept) begin
        haddr_q  <= host.addr;
        hwe_q    <= host.we;
        hsel_q   <= host.sel_ram;
        hwdata_q <= host.wdata;
      end
      if (sample_rd) begin
        rdata_q <= mem_din_i;
      end
    end
  end

  assign host.ack   = (state_q == StDone);
  assign host.abort = (state_q == StDone) && abort_q;
  assign host.rdata = rdata_q;

  // ---------------------------------------------------------------------------
  // Memory bus outputs
  // ---------------------------------------------------------------------------
  logic in_access, in_strobe;

  // gb_rst_s releases the chips in the very cycle the GB leaves reset.
  assign in_access = (state_q inside {StSetup, StStrobe, StHold}) && !gb_rst_s;
  assign in_strobe = (state_q == StStrobe) && !gb_rst_s;

  always_comb begin
    rom_hi_o      = '0;
    ram_hi_o      = '0;
    mem_addr_lo_o = '0;
    rom_cs_n_o    = 1'b1;
    ram_cs_n_o    = 1'b1;
    mem_oe_n_o    = 1'b1;
    mem_we_n_o    = 1'b1;
    mem_dout_o    = '0;
    if (bus_owner_q) begin
      rom_hi_o      = haddr_q[22:14];
      ram_hi_o      = haddr_q[16:13];
      mem_addr_lo_o = haddr_q[13:0];
      rom_cs_n_o    = ~(in_access & ~hsel_q);
      ram_cs_n_o    = ~(in_access & hsel_q);
      mem_oe_n_o    = ~(in_strobe & ~hwe_q);
      mem_we_n_o    = ~(in_strobe & hwe_q);
      mem_dout_o    = hwe_q ? hwdata_q : 8'h00;
    end else begin
      rom_hi_o   = gb_addr_hi_i[2] ? rom_bank_q : 9'h000;
      ram_hi_o   = ram_bank_q;
      // rst_n gates the raw-pin decode so the ROM stays deselected during reset.
      rom_cs_n_o = ~(~gb_addr_hi_i[3] & ~gb_read_n_i & rst_n);
      ram_cs_n_o = ~(~gb_cs_n_i & ~gb_addr_hi_i[2] & ram_en_q);
    end
  end

  assign bus_owner_o = bus_owner_q;

endmodule

// File: tb/tb_mbc5_bus_scheduler.sv
// Directed self-checking bench for mbc5_bus_scheduler (default parameters).
module tb_mbc5_bus_scheduler;
  import mbc5_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gb_rst_n, gb_write_n, gb_read_n, gb_cs_n;
  logic [3:0]  gb_addr_hi;
  logic [7:0]  gb_data;
  logic [7:0]  mem_din, mem_dout;
  logic        bus_owner;
  logic [13:0] mem_addr_lo;
  logic [8:0]  rom_hi;
  logic [3:0]  ram_hi;
  logic        rom_cs_n, ram_cs_n, mem_oe_n, mem_we_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mbc5_bus_scheduler_if host_if ();

  mbc5_bus_scheduler #(
    .SYNC_STAGES  (2),
    .SETUP_CYCLES (1),
    .STROBE_CYCLES(4),
    .HOLD_CYCLES  (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gb_rst_n_i   (gb_rst_n),
    .gb_write_n_i (gb_write_n),
    .gb_read_n_i  (gb_read_n),
    .gb_cs_n_i    (gb_cs_n),
    .gb_addr_hi_i (gb_addr_hi),
    .gb_data_i    (gb_data),
    .host         (host_if),
    .mem_din_i    (mem_din),
    .mem_dout_o   (mem_dout),
    .bus_owner_o  (bus_owner),
    .mem_addr_lo_o(mem_addr_lo),
    .rom_hi_o     (rom_hi),
    .ram_hi_o     (ram_hi),
    .rom_cs_n_o   (rom_cs_n),
    .ram_cs_n_o   (ram_cs_n),
    .mem_oe_n_o   (mem_oe_n),
    .mem_we_n_o   (mem_we_n)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gb_write(input logic [15:0] a, input logic [7:0] d);
    gb_addr_hi = a[15:12];
    gb_data    = d;
    gb_write_n = 1'b0;
    tick(4);
    gb_write_n = 1'b1;
    tick(6);
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    gb_rst_n   = 1'b1;
    gb_write_n = 1'b1;
    gb_read_n  = 1'b0;  // a GB ROM read must not select the ROM during reset
    gb_cs_n    = 1'b1;
    gb_addr_hi = 4'h0;
    gb_data    = 8'h00;
    mem_din    = 8'h00;
    host_if.req = 1'b0; host_if.we = 1'b0; host_if.sel_ram = 1'b0;
    host_if.addr = '0;  host_if.wdata = 8'h00;
    tick(2);
    checks++;
    if ({bus_owner, rom_cs_n, ram_cs_n, mem_oe_n, mem_we_n, host_if.ack, host_if.abort,
         host_if.rdata} !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got own=%b romcs=%b ramcs=%b oe=%b we=%b ack=%b abt=%b rd=%h, expected 0 1 1 1 1 0 0 00",
               bus_owner, rom_cs_n, ram_cs_n, mem_oe_n, mem_we_n, host_if.ack, host_if.abort,
               host_if.rdata);
    end
    rst_n     = 1'b1;
    gb_read_n = 1'b1;
    tick(3);
    gb_addr_hi = 4'h4;
    #1;
    checks++;
    if (rom_hi !== 9'h001 || ram_hi !== 4'h0) begin
      errors++;
      $display("FAIL reset_banks: got rom_hi=%h ram_hi=%h, expected 001 0", rom_hi, ram_hi);
    end
  endtask

  task automatic test_ram_enable;
    gb_write(16'h0000, 8'h0A);
    gb_cs_n = 1'b0; gb_addr_hi = 4'hA; gb_read_n = 1'b0;
    #1;
    checks++;
    if (ram_cs_n !== 1'b0) begin
      errors++; $display("FAIL ram_en_set: got ram_cs_n=%b, expected 0", ram_cs_n);
    end
    checks++;
    if (rom_cs_n !== 1'b1) begin
      errors++; $display("FAIL rom_cs_high_addr: got rom_cs_n=%b, expected 1", rom_cs_n);
    end
    gb_cs_n = 1'b1; gb_read_n = 1'b1;
    gb_write(16'h0000, 8'h00);
    gb_cs_n = 1'b0; gb_addr_hi = 4'hA; gb_read_n = 1'b0;
    #1;
    checks++;
    if (ram_cs_n !== 1'b1) begin
      errors++; $display("FAIL ram_en_clear: got ram_cs_n=%b, expected 1", ram_cs_n);
    end
    gb_cs_n = 1'b1; gb_read_n = 1'b1;
  endtask

  task automatic test_rom_bank;
    gb_write(16'h2000, 8'h5A);
    gb_write(16'h3000, 8'h01);
    gb_addr_hi = 4'h4; gb_read_n = 1'b0;
    #1;
    checks++;
    if (rom_hi !== 9'h15A || rom_cs_n !== 1'b0) begin
      errors++;
      $display("FAIL rom_bank_15a: got rom_hi=%h rom_cs_n=%b, expected 15a 0", rom_hi, rom_cs_n);
    end
    gb_addr_hi = 4'h0;
    #1;
    checks++;
    if (rom_hi !== 9'h000) begin
      errors++; $display("FAIL rom_bank0_window: got rom_hi=%h, expected 000", rom_hi);
    end
    gb_read_n = 1'b1;
    gb_write(16'h2000, 8'h00);
    gb_write(16'h3000, 8'h00);
    gb_addr_hi = 4'h4;
    #1;
    checks++;
    if (rom_hi !== 9'h000) begin
      errors++; $display("FAIL rom_bank_no_remap: got rom_hi=%h, expected 000", rom_hi);
    end
  endtask

  task automatic test_ram_bank;
    gb_write(16'h4000, 8'h0B);
    checks++;
    if (ram_hi !== 4'hB) begin
      errors++; $display("FAIL ram_bank_b: got ram_hi=%h, expected b", ram_hi);
    end
    gb_write(16'h6000, 8'h5A);
    gb_write(16'h8000, 8'h0A);
    gb_addr_hi = 4'h4;
    #1;
    checks++;
    if (ram_hi !== 4'hB || rom_hi !== 9'h000) begin
      errors++;
      $display("FAIL no_effect_regions: got ram_hi=%h rom_hi=%h, expected b 000", ram_hi, rom_hi);
    end
    gb_cs_n = 1'b0; gb_addr_hi = 4'hA; gb_read_n = 1'b0;
    #1;
    checks++;
    if (ram_cs_n !== 1'b1) begin
      errors++; $display("FAIL ram_en_untouched: got ram_cs_n=%b, expected 1", ram_cs_n);
    end
    gb_cs_n = 1'b1; gb_read_n = 1'b1; gb_addr_hi = 4'h0;
  endtask

  task automatic test_host_read;
    int lat = 0, oe_low = 0, we_low = 0;
    logic abt = 1'bx;
    logic [7:0] rd = 8'hxx;
    gb_rst_n = 1'b0;
    tick(4);
    checks++;
    if (bus_owner !== 1'b1) begin
      errors++; $display("FAIL host_owns_bus: got bus_owner=%b, expected 1", bus_owner);
    end
    host_if.we = 1'b0; host_if.sel_ram = 1'b0; host_if.addr = 23'h123456;
    mem_din = 8'hC3; host_if.req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 1) begin
        checks++;
        if ({rom_hi, mem_addr_lo, rom_cs_n, ram_cs_n} !== {9'h048, 14'h3456, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL rd_setup: got rom_hi=%h lo=%h romcs=%b ramcs=%b, expected 048 3456 0 1",
                   rom_hi, mem_addr_lo, rom_cs_n, ram_cs_n);
        end
      end
      if (!mem_oe_n) oe_low++;
      if (!mem_we_n) we_low++;
      if (host_if.ack) begin
        lat = k; abt = host_if.abort; rd = host_if.rdata;
        break;
      end
    end
    host_if.req = 1'b0;
    checks++;
    if (lat != 7 || oe_low != 4 || we_low != 0) begin
      errors++;
      $display("FAIL rd_timing: got latency=%0d oe_low=%0d we_low=%0d, expected 7 4 0",
               lat, oe_low, we_low);
    end
    checks++;
    if (rd !== 8'hC3 || abt !== 1'b0) begin
      errors++; $display("FAIL rd_data: got rdata=%h abort=%b, expected c3 0", rd, abt);
    end
    tick(1);
    checks++;
    if (host_if.ack !== 1'b0) begin
      errors++; $display("FAIL ack_pulse: got ack=%b, expected 0", host_if.ack);
    end
  endtask

  task automatic test_host_write;
    int lat = 0, ramcs_low = 0, we_low = 0, romcs_low = 0, oe_low = 0, dout_bad = 0;
    logic abt = 1'bx;
    host_if.we = 1'b1; host_if.sel_ram = 1'b1; host_if.addr = 23'h01E000;
    host_if.wdata = 8'h77; host_if.req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 1) begin
        checks++;
        if (ram_hi !== 4'hF) begin
          errors++; $display("FAIL wr_ram_hi: got ram_hi=%h, expected f", ram_hi);
        end
      end
      if (!ram_cs_n) ramcs_low++;
      if (!rom_cs_n) romcs_low++;
      if (!mem_oe_n) oe_low++;
      if (!mem_we_n) begin
        we_low++;
        if (mem_dout !== 8'h77) dout_bad++;
      end
      if (host_if.ack) begin
        lat = k; abt = host_if.abort;
        break;
      end
    end
    host_if.req = 1'b0;
    checks++;
    if (lat != 7 || ramcs_low != 6 || we_low != 4) begin
      errors++;
      $display("FAIL wr_timing: got latency=%0d ramcs_low=%0d we_low=%0d, expected 7 6 4",
               lat, ramcs_low, we_low);
    end
    checks++;
    if (romcs_low != 0 || oe_low != 0 || dout_bad != 0 || abt !== 1'b0) begin
      errors++;
      $display("FAIL wr_side: got romcs_low=%0d oe_low=%0d dout_bad=%0d abort=%b, expected 0 0 0 0",
               romcs_low, oe_low, dout_bad, abt);
    end
    tick(1);
  endtask

  task automatic test_abort;
    int n = 0, hi_k = 0, ack_k = 0;
    logic abt = 1'bx;
    host_if.we = 1'b0; host_if.sel_ram = 1'b0; host_if.addr = 23'h000100;
    host_if.req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (!mem_oe_n) n++;
      if (n == 2) break;
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL abort_reach_strobe: got oe_low=%0d, expected 2", n);
    end
    gb_rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (hi_k == 0 && rom_cs_n && ram_cs_n && mem_oe_n && mem_we_n) hi_k = k;
      if (host_if.ack) begin
        ack_k = k; abt = host_if.abort;
        break;
      end
    end
    host_if.req = 1'b0;
    checks++;
    if (hi_k < 1 || hi_k > 3) begin
      errors++; $display("FAIL abort_release: got bus idle after %0d clks, expected 1..3", hi_k);
    end
    checks++;
    if (ack_k != 3 || abt !== 1'b1) begin
      errors++; $display("FAIL abort_ack: got ack at %0d abort=%b, expected 3 1", ack_k, abt);
    end
    tick(1);
    gb_addr_hi = 4'h4;
    #1;
    checks++;
    if (bus_owner !== 1'b0 || rom_hi !== 9'h001 || ram_hi !== 4'h0) begin
      errors++;
      $display("FAIL abort_gb_state: got own=%b rom_hi=%h ram_hi=%h, expected 0 001 0",
               bus_owner, rom_hi, ram_hi);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ram_enable();
    test_rom_bank();
    test_ram_bank();
    test_host_read();
    test_host_write();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
